// File: rtl/router_pkg.sv
// Shared types and header layout for the router packet source.
// The header byte carries the payload length above the destination port.
package router_pkg;

  localparam int MAX_LEN = 63;
  localparam int LEN_W   = 6;
  localparam int ADDR_W  = 2;

  localparam int HDR_LEN_MSB  = 7;
  localparam int HDR_LEN_LSB  = 2;
  localparam int HDR_ADDR_MSB = 1;
  localparam int HDR_ADDR_LSB = 0;

  localparam logic [ADDR_W-1:0] INVALID_ADDR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_HEADER,
    ST_PAYLOAD,
    ST_PARITY,
    ST_GAP
  } state_e;

  function automatic logic [7:0] hdr_pack(input logic [LEN_W-1:0] len,
                                          input logic [ADDR_W-1:0] addr);
    logic [7:0] h;
    h = '0;
    h[HDR_LEN_MSB:HDR_LEN_LSB]   = len;
    h[HDR_ADDR_MSB:HDR_ADDR_LSB] = addr;
    return h;
  endfunction

endpackage

// File: rtl/router_pkt_tx_if.sv
// Request, payload and router-side signals of the packet source.
interface router_pkt_tx_if #(parameter int CNT_W = 16);
  import router_pkg::*;

  // Handshakes: a request transfers on a rising edge with req_valid && req_ready,
  // a payload byte with pl_valid && pl_ready; a router byte transfers on any edge
  // where busy is low while the source is driving header, payload or parity.
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [LEN_W-1:0]  req_len;
  logic              pl_valid;
  logic [7:0]        pl_data;
  logic              pl_ready;
  logic              busy;
  logic [7:0]        pkt_data;
  logic              pkt_valid;
  logic              done;
  logic              req_err;
  logic [CNT_W-1:0]  pkt_cnt;

  modport master (
    output req_valid, req_addr, req_len, pl_valid, pl_data, busy,
    input  req_ready, pl_ready, pkt_data, pkt_valid, done, req_err, pkt_cnt
  );

  modport slave (
    input  req_valid, req_addr, req_len, pl_valid, pl_data, busy,
    output req_ready, pl_ready, pkt_data, pkt_valid, done, req_err, pkt_cnt
  );

endinterface

// File: rtl/router_pkt_buf.sv
// Payload staging buffer: synchronous write, asynchronous read.
module router_pkt_buf
  import router_pkg::*;
(
  input  logic             clk,
  input  logic             wr_en,
  input  logic [LEN_W-1:0] wr_idx,
  input  logic [7:0]       wr_data,
  input  logic [LEN_W-1:0] rd_idx,
  output logic [7:0]       rd_data
);

  logic [7:0] mem_q [MAX_LEN];

  // Contents need no reset; every byte is written before it is read.
  always_ff @(posedge clk) begin
    if (wr_en && (int'(wr_idx) < MAX_LEN)) begin
      mem_q[wr_idx] <= wr_data;
    end
  end

  // The look-ahead read index can reach MAX_LEN on the last payload byte.
  assign rd_data = (int'(rd_idx) < MAX_LEN) ? mem_q[rd_idx] : 8'h00;

endmodule

// File: rtl/router_pkt_tx.sv
// Packet source for the router write port: buffers a whole payload, then
// streams header, payload and parity back-to-back while honouring busy.
module router_pkt_tx
  import router_pkg::*;
#(
  parameter int GAP_CYC = 2,
  parameter int CNT_W   = 16
) (
  input  logic            clk,
  input  logic            resetn,
  router_pkt_tx_if.slave  bus,
  output state_e          dbg_state
);

  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  idx_q, idx_d;
  logic [7:0]        parity_q, parity_d;
  logic [7:0]        pkt_data_q, pkt_data_d;
  logic              pkt_valid_q, pkt_valid_d;
  logic              done_q, done_d;
  logic              req_err_q, req_err_d;
  logic [CNT_W-1:0]  pkt_cnt_q, pkt_cnt_d;
  logic [GAP_W-1:0]  gap_q, gap_d;

  logic              req_acc;
  logic              pl_acc;
  logic              bus_acc;
  logic [LEN_W-1:0]  buf_rd_idx;
  logic [7:0]        buf_rd_data;

  assign req_acc = (state_q == ST_IDLE) && bus.req_valid;
  assign pl_acc  = (state_q == ST_LOAD) && bus.pl_valid;
  assign bus_acc = !bus.busy;

  // pkt_data is registered, so the buffer is read one byte ahead of the bus.
  assign buf_rd_idx = (state_q == ST_HEADER) ? '0 : idx_q + 6'd1;

  router_pkt_buf u_buf (
    .clk     (clk),
    .wr_en   (pl_acc),
    .wr_idx  (idx_q),
    .wr_data (bus.pl_data),
    .rd_idx  (buf_rd_idx),
    .rd_data (buf_rd_data)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      parity_q    <= '0;
      pkt_data_q  <= '0;
      pkt_valid_q <= 1'b0;
      done_q      <= 1'b0;
      req_err_q   <= 1'b0;
      pkt_cnt_q   <= '0;
      gap_q       <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      parity_q    <= parity_d;
      pkt_data_q  <= pkt_data_d;
      pkt_valid_q <= pkt_valid_d;
      done_q      <= done_d;
      req_err_q   <= req_err_d;
      pkt_cnt_q   <= pkt_cnt_d;
      gap_q       <= gap_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    idx_d       = idx_q;
    parity_d    = parity_q;
    pkt_data_d  = pkt_data_q;
    pkt_valid_d = pkt_valid_q;
    done_d      = 1'b0;
    req_err_d   = 1'b0;
    pkt_cnt_d   = pkt_cnt_q;
    gap_d       = gap_q;

    unique case (state_q)
      ST_IDLE: begin
        if (req_acc) begin
          addr_d = bus.req_addr;
          len_d  = bus.req_len;
          if ((bus.req_addr == INVALID_ADDR) || (bus.req_len == '0)) begin
            req_err_d = 1'b1;
          end else begin
            state_d  = ST_LOAD;
            idx_d    = '0;
            parity_d = hdr_pack(bus.req_len, bus.req_addr);
          end
        end
      end

      ST_LOAD: begin
        if (pl_acc) begin
          parity_d = parity_q ^ bus.pl_data;
          if (idx_q == len_q - 6'd1) begin
            state_d     = ST_HEADER;
            idx_d       = '0;
            pkt_data_d  = hdr_pack(len_q, addr_q);
            pkt_valid_d = 1'b1;
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end
      end

      ST_HEADER: begin
        if (bus_acc) begin
          state_d    = ST_PAYLOAD;
          pkt_data_d = buf_rd_data;
        end
      end

      // idx_q tracks the payload byte currently on the bus.
      ST_PAYLOAD: begin
        if (bus_acc) begin
          if (idx_q == len_q - 6'd1) begin
            state_d     = ST_PARITY;
            pkt_valid_d = 1'b0;
            pkt_data_d  = parity_q;
          end else begin
            idx_d      = idx_q + 6'd1;
            pkt_data_d = buf_rd_data;
          end
        end
      end

      ST_PARITY: begin
        if (bus_acc) begin
          done_d    = 1'b1;
          pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
          gap_d     = '0;
          state_d   = (GAP_CYC == 0) ? ST_IDLE : ST_GAP;
        end
      end

      ST_GAP: begin
        if (int'(gap_q) + 1 >= GAP_CYC) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.pl_ready  = (state_q == ST_LOAD);
  assign bus.pkt_data  = pkt_data_q;
  assign bus.pkt_valid = pkt_valid_q;
  assign bus.done      = done_q;
  assign bus.req_err   = req_err_q;
  assign bus.pkt_cnt   = pkt_cnt_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Self-checking bench for router_pkt_tx: each scenario task drives the DUT and
// compares the router-side byte stream against a queue built from the request.
module tb_router_pkt_tx;
  import router_pkg::*;

  localparam int GAP_CYC = 2;
  localparam int CNT_W   = 16;

  logic   clk = 1'b0;
  logic   resetn;
  state_e dbg_state;

  router_pkt_tx_if #(.CNT_W(CNT_W)) bus();

  router_pkt_tx #(.GAP_CYC(GAP_CYC), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int               n_vec = 0;
  int               n_err = 0;
  logic [CNT_W-1:0] exp_cnt;
  logic [7:0]       pl_buf [64];
  logic [7:0]       exp_q [$];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Full packet transaction; abort_after >= 0 pulls reset after that many router bytes.
  task automatic send_pkt(input logic [1:0] addr, input logic [5:0] len,
                          input int busy_pct, input int gap_pct,
                          input int stall_at, input int stall_len, input int abort_after);
    logic [7:0] par;
    int n, guard, k, cycles, held, stall_left;
    logic exp_v, stall_done;
    exp_q = {};
    par = 8'(int'(len) * 4 + int'(addr));
    exp_q.push_back(par);
    for (int i = 0; i < int'(len); i++) begin
      exp_q.push_back(pl_buf[i]);
      par = par ^ pl_buf[i];
    end
    exp_q.push_back(par);

    guard = 0;
    while (bus.req_ready !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    n_vec++;
    if (bus.req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL req_wait: req_ready=%b required 1", bus.req_ready);
      return;
    end
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    bus.req_len   = len;
    @(negedge clk);
    bus.req_valid = 1'b0;

    n = 0;
    guard = 0;
    while (n < int'(len) && guard < 3000) begin
      bus.pl_valid = ($urandom_range(99) >= gap_pct);
      bus.pl_data  = bus.pl_valid ? pl_buf[n] : 8'($urandom);
      bus.busy     = 1'($urandom_range(1));
      if (bus.pl_valid && bus.pl_ready) n++;
      @(negedge clk);
      guard++;
    end
    bus.pl_valid = 1'b0;
    n_vec++;
    if (n != int'(len) || bus.pl_ready !== 1'b0 || bus.pkt_valid !== 1'b1) begin
      n_err++;
      $display("FAIL load: bytes=%0d pl_ready=%b pkt_valid=%b required %0d,0,1",
               n, bus.pl_ready, bus.pkt_valid, len);
    end
    if (gap_pct == 0) begin
      n_vec++;
      if (guard + 1 != int'(len) + 1) begin
        n_err++;
        $display("FAIL latency: %0d cycles required %0d", guard + 1, int'(len) + 1);
      end
    end

    k = 0; cycles = 0; held = 0; stall_left = 0; stall_done = 1'b0;
    while (k < int'(len) + 2 && cycles < 5000) begin
      if (abort_after >= 0 && k == abort_after) begin
        resetn = 1'b0;
        bus.busy = 1'b0;
        #1;
        n_vec++;
        if (bus.pkt_valid !== 1'b0 || bus.pkt_data !== 8'h00 || bus.pkt_cnt !== '0 ||
            bus.req_ready !== 1'b1 || bus.done !== 1'b0) begin
          n_err++;
          $display("FAIL abort_reset: valid=%b data=%h cnt=%0d rdy=%b done=%b required 0,00,0,1,0",
                   bus.pkt_valid, bus.pkt_data, bus.pkt_cnt, bus.req_ready, bus.done);
        end
        exp_cnt = '0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        return;
      end
      if (k == stall_at && !stall_done) begin
        stall_left = stall_len;
        stall_done = 1'b1;
      end
      bus.busy = (stall_left > 0) ? 1'b1 : ($urandom_range(99) < busy_pct);
      if (stall_left > 0) stall_left--;
      bus.pl_valid = 1'($urandom_range(1));
      bus.pl_data  = 8'($urandom);
      exp_v = (k < int'(len) + 1);
      n_vec++;
      if (bus.pkt_data !== exp_q[k] || bus.pkt_valid !== exp_v) begin
        n_err++;
        $display("FAIL bus_byte[%0d]: data=%h valid=%b required %h,%b",
                 k, bus.pkt_data, bus.pkt_valid, exp_q[k], exp_v);
      end
      if (k == stall_at) held++;
      if (!bus.busy) k++;
      @(negedge clk);
      cycles++;
    end
    bus.busy = 1'b0;
    bus.pl_valid = 1'b0;
    n_vec++;
    if (k != int'(len) + 2) begin
      n_err++;
      $display("FAIL bus_timeout: %0d bytes accepted required %0d", k, int'(len) + 2);
    end
    if (stall_len > 0) begin
      n_vec++;
      if (held != stall_len + 1) begin
        n_err++;
        $display("FAIL stall_hold: byte held %0d cycles required %0d", held, stall_len + 1);
      end
    end else if (busy_pct == 0) begin
      n_vec++;
      if (cycles != int'(len) + 2) begin
        n_err++;
        $display("FAIL contiguous: %0d bus cycles required %0d", cycles, int'(len) + 2);
      end
    end

    exp_cnt = exp_cnt + CNT_W'(1);
    n_vec++;
    if (bus.done !== 1'b1 || bus.pkt_cnt !== exp_cnt) begin
      n_err++;
      $display("FAIL done_cnt: done=%b cnt=%0d required 1,%0d", bus.done, bus.pkt_cnt, exp_cnt);
    end
    for (int g = 0; g < GAP_CYC; g++) begin
      n_vec++;
      if (bus.req_ready !== 1'b0 || bus.pkt_valid !== 1'b0 || bus.pkt_data !== par) begin
        n_err++;
        $display("FAIL gap[%0d]: rdy=%b valid=%b data=%h required 0,0,%h",
                 g, bus.req_ready, bus.pkt_valid, bus.pkt_data, par);
      end
      bus.req_valid = 1'b1;
      bus.req_addr  = 2'($urandom);
      bus.req_len   = 6'($urandom);
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    n_vec++;
    if (bus.req_ready !== 1'b1 || bus.done !== 1'b0) begin
      n_err++;
      $display("FAIL gap_end: rdy=%b done=%b required 1,0", bus.req_ready, bus.done);
    end
  endtask

  task automatic test_reset();
    n_vec++;
    if (bus.pkt_data !== 8'h00 || bus.pkt_valid !== 1'b0 || bus.done !== 1'b0 ||
        bus.req_err !== 1'b0 || bus.pkt_cnt !== '0 || bus.req_ready !== 1'b1 ||
        bus.pl_ready !== 1'b0) begin
      n_err++;
      $display("FAIL reset: data=%h valid=%b done=%b err=%b cnt=%0d rdy=%b plr=%b",
               bus.pkt_data, bus.pkt_valid, bus.done, bus.req_err, bus.pkt_cnt,
               bus.req_ready, bus.pl_ready);
    end
  endtask

  task automatic test_basic();
    pl_buf[0] = 8'h11; pl_buf[1] = 8'h22; pl_buf[2] = 8'h33;
    send_pkt(2'd1, 6'd3, 0, 0, -1, 0, -1);
  endtask

  task automatic test_backpressure();
    pl_buf[0] = 8'h11; pl_buf[1] = 8'h22; pl_buf[2] = 8'h33;
    send_pkt(2'd1, 6'd3, 0, 0, 2, 3, -1);
  endtask

  task automatic test_max_len();
    for (int i = 0; i < 63; i++) pl_buf[i] = 8'(i);
    send_pkt(2'd2, 6'd63, 0, 0, -1, 0, -1);
  endtask

  task automatic test_invalid();
    logic [1:0] a_tab [2];
    logic [5:0] l_tab [2];
    a_tab[0] = 2'd3; l_tab[0] = 6'd5;
    a_tab[1] = 2'd0; l_tab[1] = 6'd0;
    for (int t = 0; t < 2; t++) begin
      bus.req_valid = 1'b1;
      bus.req_addr  = a_tab[t];
      bus.req_len   = l_tab[t];
      @(negedge clk);
      bus.req_valid = 1'b0;
      n_vec++;
      if (bus.req_err !== 1'b1 || bus.req_ready !== 1'b1) begin
        n_err++;
        $display("FAIL req_err[%0d]: err=%b rdy=%b required 1,1", t, bus.req_err, bus.req_ready);
      end
      for (int c = 0; c < 3; c++) begin
        bus.pl_valid = 1'b1;
        bus.pl_data  = 8'($urandom);
        @(negedge clk);
        n_vec++;
        if (bus.req_err !== 1'b0 || bus.pl_ready !== 1'b0 || bus.pkt_valid !== 1'b0 ||
            bus.pkt_cnt !== exp_cnt) begin
          n_err++;
          $display("FAIL invalid_idle[%0d]: err=%b plr=%b valid=%b cnt=%0d required 0,0,0,%0d",
                   t, bus.req_err, bus.pl_ready, bus.pkt_valid, bus.pkt_cnt, exp_cnt);
        end
      end
      bus.pl_valid = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) pl_buf[i] = 8'($urandom);
    send_pkt(2'd0, 6'd5, 0, 0, -1, 0, 3);
    for (int i = 0; i < 5; i++) pl_buf[i] = 8'($urandom);
    send_pkt(2'd2, 6'd5, 0, 0, -1, 0, -1);
  endtask

  task automatic test_random();
    for (int p = 0; p < 6; p++) begin
      int len;
      len = $urandom_range(1, 24);
      for (int i = 0; i < len; i++) pl_buf[i] = 8'($urandom);
      send_pkt(2'($urandom_range(0, 2)), 6'(len), 35, 35, -1, 0, -1);
    end
  endtask

  task automatic test_back_to_back();
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    exp_cnt = '0;
    @(negedge clk);
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 4; i++) pl_buf[i] = 8'($urandom);
      send_pkt(2'(p), 6'd4, 0, 0, -1, 0, -1);
    end
  endtask

  initial begin
    resetn        = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_len   = '0;
    bus.pl_valid  = 1'b0;
    bus.pl_data   = '0;
    bus.busy      = 1'b0;
    exp_cnt       = '0;
    repeat (3) @(negedge clk);
    test_reset();
    resetn = 1'b1;
    @(negedge clk);
    test_reset();
    test_basic();
    test_backpressure();
    test_max_len();
    test_invalid();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
